// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes MIPS opcode/funct into ALU operands and control, buffered
// in a 2-entry ID/EX skid register with valid/ready handshakes, flush and illegal counting.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [15:0]       imm16_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] src_a_o,
  output logic [DATA_W-1:0] src_b_o,
  output logic [2:0]        alu_control_o,
  output logic [4:0]        dest_reg_o,
  output logic              reg_write_o,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  illegal_count_o
);

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b100;
  localparam logic [2:0] AluMul = 3'b101;
  localparam logic [2:0] AluSlt = 3'b110;

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef struct packed {
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [2:0]        alu_control;
    logic [4:0]        dest_reg;
    logic              reg_write;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q;
  entry_t           out_q, skid_q, dec;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, issue;

  logic [DATA_W-1:0] imm_sext, imm_zext;
  assign imm_sext = {{(DATA_W-16){imm16_i[15]}}, imm16_i};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm16_i};

  always_comb begin
    dec             = '0;
    dec.src_a       = rs_data_i;
    dec.alu_control = AluAnd;
    case (opcode_i)
      6'b000000: begin
        dec.src_b     = rt_data_i;
        dec.dest_reg  = rd_addr_i;
        dec.reg_write = 1'b1;
        case (funct_i)
          6'b100000: dec.alu_control = AluAdd;
          6'b100010: dec.alu_control = AluSub;
          6'b100100: dec.alu_control = AluAnd;
          6'b100101: dec.alu_control = AluOr;
          6'b101010: dec.alu_control = AluSlt;
          6'b011000: dec.alu_control = AluMul;
          default: begin
            dec.src_b     = '0;
            dec.dest_reg  = '0;
            dec.reg_write = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      6'b001000: begin
        dec.alu_control = AluAdd;
        dec.src_b       = imm_sext;
        dec.dest_reg    = rt_addr_i;
        dec.reg_write   = 1'b1;
      end
      6'b001010: begin
        dec.alu_control = AluSlt;
        dec.src_b       = imm_sext;
        dec.dest_reg    = rt_addr_i;
        dec.reg_write   = 1'b1;
      end
      6'b001100: begin
        dec.alu_control = AluAnd;
        dec.src_b       = imm_zext;
        dec.dest_reg    = rt_addr_i;
        dec.reg_write   = 1'b1;
      end
      6'b001101: begin
        dec.alu_control = AluOr;
        dec.src_b       = imm_zext;
        dec.dest_reg    = rt_addr_i;
        dec.reg_write   = 1'b1;
      end
      6'b100011: begin
        dec.alu_control = AluAdd;
        dec.src_b       = imm_sext;
        dec.dest_reg    = rt_addr_i;
        dec.reg_write   = 1'b1;
      end
      6'b101011: begin
        dec.alu_control = AluAdd;
        dec.src_b       = imm_sext;
      end
      6'b000100: begin
        dec.alu_control = AluSub;
        dec.src_b       = rt_data_i;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to $zero are architecturally discarded
    if (dec.dest_reg == 5'd0) dec.reg_write = 1'b0;
  end

  assign in_ready_o  = (state_q != StTwo) && !flush_i;
  assign out_valid_o = (state_q != StEmpty);
  assign accept      = in_valid_i && in_ready_o;
  assign issue       = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept && dec.illegal && (cnt_q != CntMax)) cnt_q <= cnt_q + 1'b1;
      if (flush_i) begin
        state_q <= StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (accept) begin
              out_q   <= dec;
              state_q <= StOne;
            end
          end
          StOne: begin
            if (accept && issue) begin
              out_q <= dec;
            end else if (accept) begin
              skid_q  <= dec;
              state_q <= StTwo;
            end else if (issue) begin
              state_q <= StEmpty;
            end
          end
          StTwo: begin
            if (issue) begin
              out_q   <= skid_q;
              state_q <= StOne;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  assign src_a_o         = out_q.src_a;
  assign src_b_o         = out_q.src_b;
  assign alu_control_o   = out_q.alu_control;
  assign dest_reg_o      = out_q.dest_reg;
  assign reg_write_o     = out_q.reg_write;
  assign illegal_o       = out_q.illegal;
  assign illegal_count_o = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data, src_a, src_b;
  logic [15:0] imm16;
  logic [4:0]  rt_addr, rd_addr, dest_reg;
  logic [2:0]  alu_control;
  logic        reg_write, illegal;
  logic [7:0]  illegal_count;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_stage #(.DATA_W(32), .CNT_W(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .opcode_i       (opcode),
    .funct_i        (funct),
    .rs_data_i      (rs_data),
    .rt_data_i      (rt_data),
    .imm16_i        (imm16),
    .rt_addr_i      (rt_addr),
    .rd_addr_i      (rd_addr),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .src_a_o        (src_a),
    .src_b_o        (src_b),
    .alu_control_o  (alu_control),
    .dest_reg_o     (dest_reg),
    .reg_write_o    (reg_write),
    .illegal_o      (illegal),
    .illegal_count_o(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction with out_ready=1 from state ONE/EMPTY and check the issued entry
  task automatic send_chk(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [15:0] imm, input logic [2:0] e_alu,
                          input logic [31:0] e_b, input logic [4:0] e_dst, input logic e_rw,
                          input logic e_ill);
    opcode = op; funct = fn; imm16 = imm; in_valid = 1'b1;
    tick();
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".src_a"}, src_a, rs_data);
    chk({tag, ".alu"}, alu_control, e_alu);
    chk({tag, ".src_b"}, src_b, e_b);
    chk({tag, ".dest"}, dest_reg, e_dst);
    chk({tag, ".rw"}, reg_write, e_rw);
    chk({tag, ".ill"}, illegal, e_ill);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    opcode = '0; funct = '0; rs_data = '0; rt_data = '0; imm16 = '0;
    rt_addr = '0; rd_addr = '0;
    tick(); tick();
    chk("rst.valid", out_valid, 0);
    chk("rst.ready", in_ready, 1);
    chk("rst.src_a", src_a, 0);
    chk("rst.src_b", src_b, 0);
    chk("rst.alu", alu_control, 0);
    chk("rst.dest", dest_reg, 0);
    chk("rst.rw", reg_write, 0);
    chk("rst.ill", illegal, 0);
    chk("rst.cnt", illegal_count, 0);

    // addi with negative immediate, 1-cycle latency
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; opcode = 6'b001000; rs_data = 32'd5; imm16 = 16'hFFFF; rt_addr = 5'd3;
    tick();
    chk("addi.valid", out_valid, 1);
    chk("addi.src_a", src_a, 32'd5);
    chk("addi.src_b", src_b, 32'hFFFF_FFFF);
    chk("addi.alu", alu_control, 3'b010);
    chk("addi.dest", dest_reg, 5'd3);
    chk("addi.rw", reg_write, 1);
    in_valid = 1'b0;
    tick();
    chk("addi.drain", out_valid, 0);

    // Back-to-back sub then ori
    in_valid = 1'b1; opcode = 6'b000000; funct = 6'b100010;
    rs_data = 32'd9; rt_data = 32'd4; rd_addr = 5'd7;
    tick();
    chk("sub.alu", alu_control, 3'b100);
    chk("sub.src_b", src_b, 32'd4);
    chk("sub.dest", dest_reg, 5'd7);
    chk("sub.rw", reg_write, 1);
    opcode = 6'b001101; imm16 = 16'h8000; rs_data = 32'd1; rt_addr = 5'd2;
    tick();
    chk("ori.valid", out_valid, 1);
    chk("ori.alu", alu_control, 3'b001);
    chk("ori.src_b", src_b, 32'h0000_8000);
    chk("ori.src_a", src_a, 32'd1);
    chk("ori.dest", dest_reg, 5'd2);
    in_valid = 1'b0;
    tick();
    chk("ori.drain", out_valid, 0);

    // Backpressure: three addi entries, imm 1/2/3
    out_ready = 1'b0; opcode = 6'b001000; rt_addr = 5'd4; rs_data = 32'd0;
    in_valid = 1'b1; imm16 = 16'd1;
    tick();
    chk("bp.ready1", in_ready, 1);
    imm16 = 16'd2;
    tick();
    chk("bp.ready_two", in_ready, 0);
    chk("bp.head1", src_b, 32'd1);
    imm16 = 16'd3;
    tick();
    chk("bp.stall_head", src_b, 32'd1);
    chk("bp.stall_valid", out_valid, 1);
    chk("bp.stall_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp.head2", src_b, 32'd2);
    chk("bp.ready_one", in_ready, 1);
    tick();
    chk("bp.head3", src_b, 32'd3);
    chk("bp.valid3", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("bp.drain", out_valid, 0);

    // Flush while in TWO
    out_ready = 1'b0; in_valid = 1'b1; imm16 = 16'd11;
    tick();
    imm16 = 16'd12;
    tick();
    chk("fl.two", in_ready, 0);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("fl.ready_in_flush", in_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl.valid", out_valid, 0);
    chk("fl.ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("fl.gone1", out_valid, 0);
    tick();
    chk("fl.gone2", out_valid, 0);

    // Decode table, out_ready=1 throughout
    rs_data = 32'h10; rt_data = 32'h20; rt_addr = 5'd5; rd_addr = 5'd6;
    send_chk("andi", 6'b001100, 6'd0, 16'hFFFF, 3'b000, 32'h0000_FFFF, 5'd5, 1, 0);
    send_chk("slti", 6'b001010, 6'd0, 16'h8000, 3'b110, 32'hFFFF_8000, 5'd5, 1, 0);
    send_chk("addi+", 6'b001000, 6'd0, 16'h7FFF, 3'b010, 32'h0000_7FFF, 5'd5, 1, 0);
    send_chk("lw", 6'b100011, 6'd0, 16'h0004, 3'b010, 32'h0000_0004, 5'd5, 1, 0);
    send_chk("sw", 6'b101011, 6'd0, 16'hFFFC, 3'b010, 32'hFFFF_FFFC, 5'd0, 0, 0);
    send_chk("beq", 6'b000100, 6'd0, 16'h0001, 3'b100, 32'h20, 5'd0, 0, 0);
    send_chk("and", 6'b000000, 6'b100100, 16'h0, 3'b000, 32'h20, 5'd6, 1, 0);
    send_chk("or", 6'b000000, 6'b100101, 16'h0, 3'b001, 32'h20, 5'd6, 1, 0);
    send_chk("slt", 6'b000000, 6'b101010, 16'h0, 3'b110, 32'h20, 5'd6, 1, 0);
    send_chk("mul", 6'b000000, 6'b011000, 16'h0, 3'b101, 32'h20, 5'd6, 1, 0);
    send_chk("badfn", 6'b000000, 6'b000001, 16'h1234, 3'b000, 32'h0, 5'd0, 0, 1);
    chk("badfn.cnt", illegal_count, 1);
    rt_addr = 5'd0;
    send_chk("addi_r0", 6'b001000, 6'd0, 16'h0001, 3'b010, 32'h1, 5'd0, 0, 0);
    rt_addr = 5'd5;

    // 300 illegal opcodes; counter already at 1
    opcode = 6'b111111; imm16 = 16'h5555; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("ill.flag", illegal, 1);
      chk("ill.rw", reg_write, 0);
      chk("ill.alu", alu_control, 0);
      chk("ill.src_b", src_b, 0);
      chk("ill.cnt", illegal_count, (i + 2 > 255) ? 255 : i + 2);
    end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ill.cnt_after_flush", illegal_count, 255);

    // rd=0 add, then reset while in ONE
    out_ready = 1'b0; in_valid = 1'b1; opcode = 6'b000000; funct = 6'b100000; rd_addr = 5'd0;
    tick();
    chk("add_r0.valid", out_valid, 1);
    chk("add_r0.alu", alu_control, 3'b010);
    chk("add_r0.rw", reg_write, 0);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk("rst2.valid", out_valid, 0);
    chk("rst2.src_a", src_a, 0);
    chk("rst2.src_b", src_b, 0);
    chk("rst2.alu", alu_control, 0);
    chk("rst2.ill", illegal, 0);
    chk("rst2.cnt", illegal_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
